// File: rtl/game_state_poller_if.sv
// Read-only memory port between the game-state poller and the data/video memory.
// mem_addr is registered by the poller; mem_rd is stable a fixed number of edges later.
interface game_state_poller_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;

  modport master (output mem_addr, input mem_rd);
  modport slave  (input mem_addr, output mem_rd);
endinterface

// File: rtl/game_state_poller.sv
// Sweeps the four game-state words into a shadow set and commits it to the
// drawer-facing outputs only on a frame boundary, so a frame never sees a torn mix.
module game_state_poller #(
  parameter logic [31:0] ADDR_P1_LIVES = 32'h0000_6000,
  parameter logic [31:0] ADDR_P2_LIVES = 32'h0000_7000,
  parameter logic [31:0] ADDR_DOOR1    = 32'h0000_3000,
  parameter logic [31:0] ADDR_DOOR2    = 32'h0000_4000,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                  VGA_CLK,
  input  logic                  reset,
  input  logic                  frame_start,
  game_state_poller_if.master   mem,
  output logic [1:0]            p1_lives,
  output logic [1:0]            p2_lives,
  output logic [1:0]            correct_door_1,
  output logic [1:0]            correct_door_2,
  output logic                  state_valid,
  output logic                  state_changed,
  output logic                  bad_door,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_PENDING = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      wait_cnt;
  logic [1:0]      slot;
  logic [3:0][1:0] shadow;
  logic [1:0]      cap_val;
  logic            cap_bad;

  assign state_dbg = state;

  function automatic logic [31:0] slot_addr(input logic [1:0] s);
    case (s)
      2'd0:    slot_addr = ADDR_P1_LIVES;
      2'd1:    slot_addr = ADDR_P2_LIVES;
      2'd2:    slot_addr = ADDR_DOOR1;
      default: slot_addr = ADDR_DOOR2;
    endcase
  endfunction

  // Door slots (2 and 3) never hold 2'b11; such a read is stored as 0 and flagged.
  always_comb begin
    cap_val = mem.mem_rd[1:0];
    cap_bad = 1'b0;
    if (slot[1] && mem.mem_rd[1:0] == 2'b11) begin
      cap_val = 2'b00;
      cap_bad = 1'b1;
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state          <= S_ISSUE;
      mem.mem_addr   <= ADDR_P1_LIVES;
      wait_cnt       <= 3'd0;
      slot           <= 2'd0;
      shadow         <= '0;
      p1_lives       <= 2'b11;
      p2_lives       <= 2'b11;
      correct_door_1 <= 2'b00;
      correct_door_2 <= 2'b00;
      state_valid    <= 1'b0;
      state_changed  <= 1'b0;
      bad_door       <= 1'b0;
    end else begin
      state_changed <= 1'b0;
      case (state)
        S_ISSUE: begin
          mem.mem_addr <= slot_addr(slot);
          wait_cnt     <= 3'(READ_LATENCY);
          state        <= S_WAIT;
        end
        // Leaving on the cycle the count reaches zero gives exactly READ_LATENCY WAIT cycles.
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt <= 3'd1) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shadow[slot] <= cap_val;
          if (cap_bad) bad_door <= 1'b1;
          if (slot == 2'd3) begin
            slot  <= 2'd0;
            state <= S_PENDING;
          end else begin
            slot  <= slot + 2'd1;
            state <= S_ISSUE;
          end
        end
        default: begin
          if (frame_start) begin
            p1_lives       <= shadow[0];
            p2_lives       <= shadow[1];
            correct_door_1 <= shadow[2];
            correct_door_2 <= shadow[3];
            state_valid    <= 1'b1;
            state_changed  <= ({correct_door_2, correct_door_1, p2_lives, p1_lives} != shadow);
            state          <= S_ISSUE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_poller.sv
// Bench for game_state_poller: two instances (read latency 1 and 3) run in lockstep
// against a cycle-count model of the sweep/commit rules plus directed vector tables.
module tb_game_state_poller;

  localparam logic [31:0] A_P1 = 32'h0000_6000;
  localparam logic [31:0] A_P2 = 32'h0000_7000;
  localparam logic [31:0] A_D1 = 32'h0000_3000;
  localparam logic [31:0] A_D2 = 32'h0000_4000;

  logic VGA_CLK = 1'b0;
  logic reset;
  logic frame_start;

  always #5 VGA_CLK = ~VGA_CLK;

  game_state_poller_if bus_a ();
  game_state_poller_if bus_b ();

  logic [1:0]  p1 [2];
  logic [1:0]  p2 [2];
  logic [1:0]  d1 [2];
  logic [1:0]  d2 [2];
  logic        valid [2];
  logic        chg [2];
  logic        bad [2];
  logic [1:0]  dbg [2];
  logic [31:0] addr_act [2];

  assign addr_act[0] = bus_a.mem_addr;
  assign addr_act[1] = bus_b.mem_addr;

  game_state_poller #(.READ_LATENCY(1)) dut_a (
    .VGA_CLK(VGA_CLK), .reset(reset), .frame_start(frame_start), .mem(bus_a.master),
    .p1_lives(p1[0]), .p2_lives(p2[0]), .correct_door_1(d1[0]), .correct_door_2(d2[0]),
    .state_valid(valid[0]), .state_changed(chg[0]), .bad_door(bad[0]), .state_dbg(dbg[0]));

  game_state_poller #(.READ_LATENCY(3)) dut_b (
    .VGA_CLK(VGA_CLK), .reset(reset), .frame_start(frame_start), .mem(bus_b.master),
    .p1_lives(p1[1]), .p2_lives(p2[1]), .correct_door_1(d1[1]), .correct_door_2(d2[1]),
    .state_valid(valid[1]), .state_changed(chg[1]), .bad_door(bad[1]), .state_dbg(dbg[1]));

  // Per-instance memory contents: index 0..3 = P1, P2, DOOR1, DOOR2 words.
  logic [31:0] mem_w [2][4];

  function automatic logic [31:0] lookup(input int k, input logic [31:0] a);
    case (a)
      A_P1:    lookup = mem_w[k][0];
      A_P2:    lookup = mem_w[k][1];
      A_D1:    lookup = mem_w[k][2];
      A_D2:    lookup = mem_w[k][3];
      default: lookup = 32'hDEAD_BEEE;
    endcase
  endfunction

  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always_ff @(posedge VGA_CLK) begin
    pipe_a    <= lookup(0, bus_a.mem_addr);
    pipe_b[0] <= lookup(1, bus_b.mem_addr);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.mem_rd = pipe_a;
  assign bus_b.mem_rd = pipe_b[2];

  // ---------------- reference model ----------------
  int          rl [2] = '{1, 3};
  int          age [2];
  logic [1:0]  exp_o [2][4];
  logic        exp_valid [2];
  logic        exp_chg [2];
  logic        exp_bad [2];
  logic [31:0] exp_addr [2];
  logic        committed [2];
  logic [31:0] addr_tab [4] = '{A_P1, A_P2, A_D1, A_D2};
  bit          rand_mem;

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] san(input int slot, input logic [31:0] w);
    if (slot >= 2 && w[1:0] == 2'b11) return 2'b00;
    return w[1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      age[k] = 0;
      exp_o[k] = '{2'b11, 2'b11, 2'b00, 2'b00};
      exp_valid[k] = 1'b0;
      exp_chg[k] = 1'b0;
      exp_bad[k] = 1'b0;
      exp_addr[k] = A_P1;
      committed[k] = 1'b0;
    end
  endtask

  // age = clock edges since the current sweep began; a sweep is 4*(latency+2) edges.
  task automatic model_edge(input int k, input logic fs);
    int sw;
    int slen;
    logic [1:0] nv [4];
    logic diff;
    slen = rl[k] + 2;
    sw = 4 * slen;
    committed[k] = 1'b0;
    if (fs && age[k] >= sw) begin
      diff = 1'b0;
      for (int i = 0; i < 4; i++) begin
        nv[i] = san(i, mem_w[k][i]);
        if (nv[i] != exp_o[k][i]) diff = 1'b1;
      end
      exp_o[k] = nv;
      exp_valid[k] = 1'b1;
      exp_chg[k] = diff;
      age[k] = 0;
      committed[k] = 1'b1;
    end else begin
      exp_chg[k] = 1'b0;
      if (age[k] < sw) begin
        age[k]++;
        exp_addr[k] = addr_tab[(age[k] - 1) / slen];
        if (age[k] == 3 * slen && mem_w[k][2][1:0] == 2'b11) exp_bad[k] = 1'b1;
        if (age[k] == sw && mem_w[k][3][1:0] == 2'b11) exp_bad[k] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check("p1_lives", k, 32'(p1[k]), 32'(exp_o[k][0]));
      check("p2_lives", k, 32'(p2[k]), 32'(exp_o[k][1]));
      check("door_1", k, 32'(d1[k]), 32'(exp_o[k][2]));
      check("door_2", k, 32'(d2[k]), 32'(exp_o[k][3]));
      check("state_valid", k, 32'(valid[k]), 32'(exp_valid[k]));
      check("state_changed", k, 32'(chg[k]), 32'(exp_chg[k]));
      check("bad_door", k, 32'(bad[k]), 32'(exp_bad[k]));
      check("mem_addr", k, addr_act[k], exp_addr[k]);
    end
  endtask

  task automatic tick(input logic fs);
    frame_start = fs;
    @(posedge VGA_CLK);
    for (int k = 0; k < 2; k++) model_edge(k, fs);
    #1;
    check_all();
    frame_start = 1'b0;
    if (rand_mem) begin
      for (int k = 0; k < 2; k++)
        if (committed[k])
          for (int i = 0; i < 4; i++) mem_w[k][i] = $urandom();
    end
  endtask

  // Run n edges, pulsing frame_start on the last one.
  task automatic run_to_pulse(input int n);
    for (int c = 1; c <= n; c++) tick(c == n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge VGA_CLK);
    @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    reset = 1'b0;
  endtask

  task automatic load_mem(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    for (int k = 0; k < 2; k++) mem_w[k] = '{w0, w1, w2, w3};
  endtask

  typedef struct {
    logic [31:0] w [4];
    int          fs_edge;
    logic [1:0]  e_p1, e_p2, e_d1, e_d2;
    logic        e_valid, e_chg, e_bad;
  } vec_t;

  vec_t vecs [5];

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    rand_mem = 1'b0;
    load_mem(32'd2, 32'd1, 32'd1, 32'd2);
    model_reset();

    vecs[0] = '{w: '{32'd2, 32'd1, 32'd1, 32'd2}, fs_edge: 20,
                e_p1: 2, e_p2: 1, e_d1: 1, e_d2: 2, e_valid: 1, e_chg: 1, e_bad: 0};
    vecs[1] = '{w: '{32'd3, 32'd0, 32'd2, 32'hFFFF_FFFF}, fs_edge: 20,
                e_p1: 3, e_p2: 0, e_d1: 2, e_d2: 0, e_valid: 1, e_chg: 1, e_bad: 1};
    vecs[2] = '{w: '{32'd2, 32'd1, 32'd1, 32'd2}, fs_edge: 5,
                e_p1: 3, e_p2: 3, e_d1: 0, e_d2: 0, e_valid: 0, e_chg: 0, e_bad: 0};
    vecs[3] = '{w: '{32'hABCD_0001, 32'hFFFF_FFFC, 32'h0000_0003, 32'h0000_0005}, fs_edge: 13,
                e_p1: 1, e_p2: 0, e_d1: 0, e_d2: 1, e_valid: 1, e_chg: 1, e_bad: 1};
    vecs[4] = '{w: '{32'd1, 32'd1, 32'd1, 32'd1}, fs_edge: 12,
                e_p1: 3, e_p2: 3, e_d1: 0, e_d2: 0, e_valid: 0, e_chg: 0, e_bad: 0};

    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].w[0], vecs[v].w[1], vecs[v].w[2], vecs[v].w[3]);
      do_reset();
      run_to_pulse(vecs[v].fs_edge);
      check("tbl_p1", 0, 32'(p1[0]), 32'(vecs[v].e_p1));
      check("tbl_p2", 0, 32'(p2[0]), 32'(vecs[v].e_p2));
      check("tbl_d1", 0, 32'(d1[0]), 32'(vecs[v].e_d1));
      check("tbl_d2", 0, 32'(d2[0]), 32'(vecs[v].e_d2));
      check("tbl_valid", 0, 32'(valid[0]), 32'(vecs[v].e_valid));
      check("tbl_changed", 0, 32'(chg[0]), 32'(vecs[v].e_chg));
      check("tbl_bad", 0, 32'(bad[0]), 32'(vecs[v].e_bad));
    end

    // Identical second sweep: outputs hold, no change pulse.
    load_mem(32'd2, 32'd1, 32'd1, 32'd2);
    do_reset();
    run_to_pulse(20);
    check("commit_pulse", 0, 32'(chg[0]), 32'd1);
    tick(1'b0);
    check("pulse_one_cycle", 0, 32'(chg[0]), 32'd0);
    run_to_pulse(12);
    check("same_commit_p1", 0, 32'(p1[0]), 32'd2);
    check("same_commit_chg", 0, 32'(chg[0]), 32'd0);
    check("same_commit_valid", 0, 32'(valid[0]), 32'd1);

    // Mid-sweep pulse ignored, later pulse commits.
    do_reset();
    run_to_pulse(5);
    check("midsweep_valid", 0, 32'(valid[0]), 32'd0);
    run_to_pulse(25);
    check("late_valid", 0, 32'(valid[0]), 32'd1);
    check("late_d2", 0, 32'(d2[0]), 32'd2);

    // Bad door flag sticks across a clean sweep.
    load_mem(32'd2, 32'd1, 32'd1, 32'hFFFF_FFFF);
    do_reset();
    run_to_pulse(20);
    check("bad_d2", 0, 32'(d2[0]), 32'd0);
    check("bad_set", 0, 32'(bad[0]), 32'd1);
    mem_w[0][3] = 32'd2;
    run_to_pulse(13);
    check("clean_d2", 0, 32'(d2[0]), 32'd2);
    check("bad_sticky", 0, 32'(bad[0]), 32'd1);

    // Reset during slot 2 WAIT of a fresh sweep.
    load_mem(32'd2, 32'd1, 32'd1, 32'd2);
    do_reset();
    run_to_pulse(20);
    for (int c = 0; c < 7; c++) tick(1'b0);
    check("pre_reset_state", 0, 32'(dbg[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_p1", 0, 32'(p1[0]), 32'd3);
    check("rst_p2", 0, 32'(p2[0]), 32'd3);
    check("rst_d1", 0, 32'(d1[0]), 32'd0);
    check("rst_valid", 0, 32'(valid[0]), 32'd0);
    check("rst_addr", 0, addr_act[0], A_P1);
    do_reset();
    run_to_pulse(5);
    check("post_rst_nocommit", 0, 32'(valid[0]), 32'd0);

    // Randomized traffic against the model for both latencies.
    rand_mem = 1'b1;
    do_reset();
    for (int c = 0; c < 800; c++) tick($urandom_range(0, 9) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_poller.md
Name: game_state_poller

Overview:
- Sits between the data/video memory read port and the screen drawer.
- Sweeps four memory-mapped game-state words: player 1 lives, player 2 lives, correct door 1 and correct door 2.
- Captures each word with a fixed read latency into a shadow set.
- Commits the shadow set to its outputs only at a frame boundary, so the drawer never sees a torn mix of old and new values within one frame.

Parameters:
- ADDR_P1_LIVES, 32'h0000_6000, address of player 1 lives word
- ADDR_P2_LIVES, 32'h0000_7000, address of player 2 lives word
- ADDR_DOOR1, 32'h0000_3000, address of correct door 1 word
- ADDR_DOOR2, 32'h0000_4000, address of correct door 2 word
- READ_LATENCY, 1, clock edges from the memory sampling mem_addr to mem_rd being stable (range 1..7)

Ports:
- VGA_CLK  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- mem_rd  in  32  read data from memory
- mem_addr  out  32  registered read address to memory
- p1_lives  out  2  committed player 1 lives
- p2_lives  out  2  committed player 2 lives
- correct_door_1  out  2  committed door for player 1
- correct_door_2  out  2  committed door for player 2
- state_valid  out  1  high once the first commit has occurred
- state_changed  out  1  one-cycle pulse on a commit that altered any output
- bad_door  out  1  sticky flag: a door word read as 2'b11

Behaviour:
- Reset (async) sets:
  - mem_addr = ADDR_P1_LIVES
  - p1_lives = p2_lives = 2'b11
  - correct_door_1 = correct_door_2 = 2'b00
  - state_valid = state_changed = bad_door = 0
  - shadow registers = 0
  - slot index = 0, wait counter = 0
  - state = ISSUE
- FSM states:
  - ISSUE: mem_addr <= address of current slot (0 = P1, 1 = P2, 2 = DOOR1, 3 = DOOR2); load wait counter with READ_LATENCY; go to WAIT.
  - WAIT: decrement the counter each cycle; when it is 0, go to CAPTURE.
  - CAPTURE: shadow[slot] <= mem_rd[1:0]. If slot < 3: slot + 1, go to ISSUE. If slot == 3: slot <= 0, go to PENDING.
  - PENDING: hold mem_addr; wait for frame_start.
- Slot timing: 1 (ISSUE) + READ_LATENCY (WAIT) + 1 (CAPTURE) = READ_LATENCY + 2 cycles. A full sweep takes 4*(READ_LATENCY + 2) cycles; 12 cycles at default.
- mem_addr stays constant from ISSUE through CAPTURE of the same slot.
- Door sanitising, applied at CAPTURE for slots 2 and 3:
  - mem_rd[1:0] == 2'b11 stores 2'b00 in the shadow and sets bad_door.
  - bad_door clears only on reset.
- Lives words are stored unmodified (0..3). Bits [31:2] of mem_rd are ignored.
- Commit happens when frame_start is high in PENDING:
  - All four outputs <= shadow on that edge.
  - state_valid <= 1.
  - state_changed <= 1 for exactly one cycle if any output differs from its prior value, else 0.
  - Next state is ISSUE with slot 0, i.e. a new sweep starts immediately.
- frame_start in any state other than PENDING is ignored: no commit, outputs hold, the sweep continues, and no pulse is queued.
- frame_start arriving on the same edge the FSM enters PENDING is not a commit; the next pulse is required.
- A commit is possible only if a full sweep finished before that frame_start. A frame shorter than one sweep therefore skips commits; outputs hold.
- state_changed is 0 in all cycles other than the one following a qualifying commit.
- Reset asserted mid-sweep discards partial shadow data. After release the first commit requires one full new sweep.
- The block never writes memory and performs no handshake beyond fixed latency.

Test Plan:
- Reset then a memory model returning 6000→2, 7000→1, 3000→1, 4000→2 (latency 1), with frame_start at cycle 20:
  - mem_addr sequence is 6000, 7000, 3000, 4000, holding 3 cycles each.
  - Outputs commit to 2, 1, 1, 2 one cycle after the pulse.
  - state_valid = 1 and state_changed pulses once.
- Same memory contents, second frame_start after a further full sweep: outputs unchanged, state_changed stays 0.
- frame_start at cycle 5, mid-sweep: no output change and state_valid stays 0. A pulse at cycle 30 commits normally.
- Door2 word = 32'hFFFF_FFFF: correct_door_2 commits 2'b00, bad_door = 1 and stays 1 across later clean sweeps until reset.
- READ_LATENCY = 3 with a 3-deep pipelined memory model:
  - Each slot lasts 5 cycles; the sweep completes in 20 cycles.
  - Captured values match memory exactly (no stale slot data).
- Reset asserted during slot 2 WAIT, then released:
  - Outputs return to 3, 3, 0, 0 with state_valid = 0.
  - mem_addr = 6000.
  - A frame_start 5 cycles after release does not commit.
